// File: rtl/scalar_rf_mp.sv
// Multi-port scalar register file: async reads, prioritised sync writes, optional
// write-through bypass, per-register busy scoreboard and a sticky finish flag.
module scalar_rf_mp #(
    parameter int WIDTH     = 19,
    parameter int DEPTH     = 32,
    parameter int NRD       = 3,
    parameter int NWR       = 2,
    parameter int BYPASS    = 1,
    parameter int ZERO_R0   = 0,
    parameter int RST_IDX_A = 1,
    parameter int RST_VAL_A = 200000,
    parameter int RST_IDX_B = 10,
    parameter int RST_VAL_B = 199983,
    parameter int FIN_IDX   = 28,
    parameter int FIN_VAL   = 333,
    localparam int AW       = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NRD*AW-1:0]    rs_addr,
    output logic [NRD*WIDTH-1:0] rd_data,
    output logic [NRD-1:0]       rd_busy,
    input  logic [NWR-1:0]       we,
    input  logic [NWR*AW-1:0]    wa,
    input  logic [NWR*WIDTH-1:0] wd,
    input  logic                 rsv_en,
    input  logic [AW-1:0]        rsv_addr,
    output logic                 finish
);

    localparam logic [WIDTH-1:0] RST_A = WIDTH'(RST_VAL_A);
    localparam logic [WIDTH-1:0] RST_B = WIDTH'(RST_VAL_B);
    localparam logic [WIDTH-1:0] FIN_V = WIDTH'(FIN_VAL);
    localparam bit               FIN_OK = (FIN_IDX >= 0) && (FIN_IDX < DEPTH);

    logic [WIDTH-1:0] regs   [DEPTH];
    logic [WIDTH-1:0] wr_val [DEPTH];
    logic [DEPTH-1:0] wr_hit;
    logic [DEPTH-1:0] rsv_hit;
    logic [DEPTH-1:0] busy;
    logic             fin_match;

    function automatic logic in_range(input logic [AW-1:0] a);
        return {1'b0, a} < (AW+1)'(DEPTH);
    endfunction

    function automatic logic is_r0(input logic [AW-1:0] a);
        return (ZERO_R0 != 0) && (a == '0);
    endfunction

    // Later write ports overwrite earlier ones, so the highest index wins a shared address.
    always_comb begin
        wr_hit  = '0;
        rsv_hit = '0;
        for (int i = 0; i < DEPTH; i++) begin
            wr_val[i] = '0;
        end
        for (int j = 0; j < NWR; j++) begin
            if (we[j] && in_range(wa[j*AW +: AW]) && !is_r0(wa[j*AW +: AW])) begin
                wr_hit[wa[j*AW +: AW]] = 1'b1;
                wr_val[wa[j*AW +: AW]] = wd[j*WIDTH +: WIDTH];
            end
        end
        if (rsv_en && in_range(rsv_addr) && !is_r0(rsv_addr)) begin
            rsv_hit[rsv_addr] = 1'b1;
        end
    end

    always_comb begin
        rd_data = '0;
        rd_busy = '0;
        for (int k = 0; k < NRD; k++) begin
            if (in_range(rs_addr[k*AW +: AW]) && !is_r0(rs_addr[k*AW +: AW])) begin
                if ((BYPASS != 0) && wr_hit[rs_addr[k*AW +: AW]]) begin
                    rd_data[k*WIDTH +: WIDTH] = wr_val[rs_addr[k*AW +: AW]];
                end else begin
                    rd_data[k*WIDTH +: WIDTH] = regs[rs_addr[k*AW +: AW]];
                    rd_busy[k]                = busy[rs_addr[k*AW +: AW]];
                end
            end
        end
    end

    for (genvar i = 0; i < DEPTH; i++) begin : g_reg
        localparam logic [WIDTH-1:0] INIT =
            ((ZERO_R0 != 0) && (i == 0)) ? '0 :
            (i == RST_IDX_A)             ? RST_A :
            (i == RST_IDX_B)             ? RST_B : '0;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                regs[i] <= INIT;
            end else if (wr_hit[i]) begin
                regs[i] <= wr_val[i];
            end
        end
    end

    // A reservation in the same cycle as a write is the newer producer, so it keeps busy set.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy <= '0;
        end else begin
            busy <= rsv_hit | (busy & ~wr_hit);
        end
    end

    if (FIN_OK) begin : g_fin
        assign fin_match = (regs[FIN_IDX] == FIN_V);
    end else begin : g_nofin
        assign fin_match = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            finish <= 1'b0;
        end else begin
            finish <= finish | fin_match;
        end
    end

endmodule
